// File: rtl/hyp_share_arbiter_if.sv
// Bundles the requester fabric, the sqrt-unit handshake and the response
// channel of the shared hypotenuse arbiter.
interface hyp_share_arbiter_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) ();
  logic [NREQ-1:0]    rq_req;
  logic [NREQ*DW-1:0] rq_s0;
  logic [NREQ*DW-1:0] rq_s1;
  logic [NREQ-1:0]    rq_gnt;
  logic               sq_start;
  logic [DW-1:0]      sq_rad;
  logic               sq_busy;
  logic               sq_valid;
  logic [DW-1:0]      sq_root;
  logic               rs_valid;
  logic               rs_ready;
  logic [IDW-1:0]     rs_id;
  logic [DW-1:0]      rs_hyp;
  logic [1:0]         rs_err;
  logic               ar_busy;

  // Arbiter view
  modport master (
    input  rq_req, rq_s0, rq_s1, sq_busy, sq_valid, sq_root, rs_ready,
    output rq_gnt, sq_start, sq_rad, rs_valid, rs_id, rs_hyp, rs_err, ar_busy
  );

  // Requesters, sqrt unit and response sink view
  modport slave (
    output rq_req, rq_s0, rq_s1, sq_busy, sq_valid, sq_root, rs_ready,
    input  rq_gnt, sq_start, sq_rad, rs_valid, rs_id, rs_hyp, rs_err, ar_busy
  );
endinterface

// File: rtl/hyp_share_arbiter.sv
// Round-robin arbiter sharing one integer sqrt unit among NREQ hypotenuse
// requesters; screens overflow and zero-side cases and times out the sqrt.
module hyp_share_arbiter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned TMO  = 64
) (
  input  logic                hy_clock,
  input  logic                hy_rst,
  hyp_share_arbiter_if.master bus
);
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = 2 * DW + 1;
  localparam int unsigned CW = $clog2(TMO + 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [DW-1:0]  r_s0;
  logic [DW-1:0]  r_s1;
  logic [DW-1:0]  r_rad;
  logic [DW-1:0]  r_hyp;
  logic [1:0]     r_err;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf;
  logic           r_zero;
  logic           r_start;
  logic           r_valid;
  logic           r_busy;

  logic            w_found;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_sel;
  logic            w_go;
  logic [NREQ-1:0] w_gnt;
  logic [DW-1:0]   w_s0;
  logic [DW-1:0]   w_s1;
  logic [PW-1:0]   w_sq0;
  logic [PW-1:0]   w_sq1;
  logic [SW-1:0]   w_sum;
  logic            w_ovf;
  logic            w_zero;

  // First requester at or above the pointer, wrapping at NREQ
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sel   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && bus.rq_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Sum of squares is one bit wider than 2*DW so two full-scale sides cannot wrap
  always_comb begin
    w_s0   = bus.rq_s0[32'(w_sel) * DW +: DW];
    w_s1   = bus.rq_s1[32'(w_sel) * DW +: DW];
    w_sq0  = PW'(w_s0) * PW'(w_s0);
    w_sq1  = PW'(w_s1) * PW'(w_s1);
    w_sum  = SW'(w_sq0) + SW'(w_sq1);
    w_ovf  = |w_sum[SW-1:DW];
    w_zero = (w_s0 == '0) || (w_s1 == '0);
    w_go   = (r_state == S_IDLE) && w_found && !bus.sq_busy && !hy_rst;
    w_gnt  = w_go ? (NREQ'(1) << w_sel) : '0;
  end

  always_ff @(posedge hy_clock) begin
    if (hy_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_s0    <= '0;
      r_s1    <= '0;
      r_rad   <= '0;
      r_hyp   <= '0;
      r_err   <= ERR_OK;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_id    <= w_sel;
            r_s0    <= w_s0;
            r_s1    <= w_s1;
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
            // Start and radicand are registered here so they appear during CHECK
            r_start <= !w_ovf && !w_zero;
            r_rad   <= (!w_ovf && !w_zero) ? w_sum[DW-1:0] : '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_start <= 1'b0;
          if (r_ovf) begin
            r_hyp   <= '0;
            r_err   <= ERR_OVF;
            r_valid <= 1'b1;
            r_state <= S_RESP;
          end else if (r_zero) begin
            r_hyp   <= r_s0 | r_s1;
            r_err   <= ERR_OK;
            r_valid <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A result arriving on the timeout cycle still wins
          if (bus.sq_valid) begin
            r_hyp   <= bus.sq_root;
            r_err   <= ERR_OK;
            r_valid <= 1'b1;
            r_rad   <= '0;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TMO - 1)) begin
            r_hyp   <= '0;
            r_err   <= ERR_TMO;
            r_valid <= 1'b1;
            r_rad   <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rs_ready) begin
            r_valid <= 1'b0;
            r_hyp   <= '0;
            r_err   <= ERR_OK;
            r_ptr   <= (32'(r_id) == NREQ - 1) ? '0 : r_id + 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rq_gnt   = w_gnt;
  assign bus.sq_start = r_start;
  assign bus.sq_rad   = r_rad;
  assign bus.rs_valid = r_valid;
  assign bus.rs_id    = r_id;
  assign bus.rs_hyp   = r_hyp;
  assign bus.rs_err   = r_err;
  assign bus.ar_busy  = r_busy;
endmodule

// File: tb/tb_hyp_share_arbiter.sv
// Directed bench for hyp_share_arbiter: vector table of single transactions
// plus hand sequences for fairness, busy gating, backpressure and reset.
module tb_hyp_share_arbiter;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned TMO  = 64;
  localparam int          NV   = 11;

  logic hy_clock = 1'b0;
  logic hy_rst;
  always #5 hy_clock = ~hy_clock;

  hyp_share_arbiter_if #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) ifc ();

  hyp_share_arbiter #(.DW(DW), .NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
    .hy_clock (hy_clock),
    .hy_rst   (hy_rst),
    .bus      (ifc)
  );

  // Sqrt unit model: root of the radicand three cycles after the start pulse
  logic        m_en, m_pend, m_valid;
  logic [1:0]  m_cnt;
  logic [31:0] m_root;
  logic        tb_busy, tb_valid;
  logic [31:0] tb_root;

  function automatic logic [31:0] isqrt(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] c;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      c = r | (32'd1 << b);
      if (64'(c) * 64'(c) <= 64'(v)) r = c;
    end
    return r;
  endfunction

  always @(posedge hy_clock) begin
    if (hy_rst) begin
      m_pend  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 2'd0;
      m_root  <= '0;
    end else begin
      m_valid <= 1'b0;
      if (ifc.sq_start && m_en) begin
        m_pend <= 1'b1;
        m_cnt  <= 2'd2;
        m_root <= isqrt(ifc.sq_rad);
      end else if (m_pend) begin
        if (m_cnt == 2'd1) begin
          m_pend  <= 1'b0;
          m_valid <= 1'b1;
        end
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  assign ifc.sq_busy  = m_pend | tb_busy;
  assign ifc.sq_valid = m_valid | tb_valid;
  assign ifc.sq_root  = m_valid ? m_root : tb_root;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hy_clock);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] b);
    ifc.rq_s0[l*32 +: 32] = a;
    ifc.rq_s1[l*32 +: 32] = b;
  endtask

  // Clears requests after the grant cycle, waits for rs_valid, notes any start pulse
  task automatic wait_resp(output int lat, output int st_t, output logic [31:0] rad);
    lat  = 0;
    st_t = 0;
    rad  = '0;
    for (int t = 1; t <= 200; t++) begin
      tick();
      ifc.rq_req = '0;
      #1;
      if (ifc.sq_start && st_t == 0) begin
        st_t = t;
        rad  = ifc.sq_rad;
      end
      if (ifc.rs_valid) begin
        lat = t;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] s0;
    logic [31:0] s1;
    bit          mdl;
    logic [1:0]  id;
    logic [31:0] hyp;
    logic [1:0]  err;
    int          st_t;
    logic [31:0] rad;
    int          lat;
  } vec_t;

  vec_t vecs[NV];
  logic [3:0] fair_gnt[5];
  logic [1:0] fair_id[5];

  initial begin
    int lat, st_t, ng, nr;
    logic [31:0] rad;

    vecs[0]  = '{4'b0010, 32'd3,        32'd4,      1'b1, 2'd1, 32'd5,      2'b00, 1, 32'd25,         5};
    vecs[1]  = '{4'b0100, 32'h0001_0000, 32'd1,     1'b1, 2'd2, 32'd0,      2'b01, 0, 32'd0,          2};
    vecs[2]  = '{4'b0001, 32'd0,        32'd7,      1'b1, 2'd0, 32'd7,      2'b00, 0, 32'd0,          2};
    vecs[3]  = '{4'b0001, 32'd0,        32'd0,      1'b1, 2'd0, 32'd0,      2'b00, 0, 32'd0,          2};
    vecs[4]  = '{4'b1000, 32'd5,        32'd12,     1'b1, 2'd3, 32'd13,     2'b00, 1, 32'd169,        5};
    vecs[5]  = '{4'b0010, 32'hFFFF_FFFF, 32'd0,     1'b1, 2'd1, 32'd0,      2'b01, 0, 32'd0,          2};
    vecs[6]  = '{4'b0100, 32'h0000_FFFF, 32'd0,     1'b1, 2'd2, 32'hFFFF,   2'b00, 0, 32'd0,          2};
    vecs[7]  = '{4'b0001, 32'h0001_0000, 32'd0,     1'b1, 2'd0, 32'd0,      2'b01, 0, 32'd0,          2};
    vecs[8]  = '{4'b1000, 32'hB504,     32'hB504,   1'b1, 2'd3, 32'd65534,  2'b00, 1, 32'd4294791200, 5};
    vecs[9]  = '{4'b0001, 32'd7,        32'd0,      1'b1, 2'd0, 32'd7,      2'b00, 0, 32'd0,          2};
    vecs[10] = '{4'b0010, 32'd3,        32'd4,      1'b0, 2'd1, 32'd0,      2'b10, 1, 32'd25,         66};
    fair_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    hy_rst = 1'b1;
    m_en = 1'b1;
    tb_busy = 1'b0;
    tb_valid = 1'b0;
    tb_root = '0;
    ifc.rq_req = '0;
    ifc.rq_s0 = '0;
    ifc.rq_s1 = '0;
    ifc.rs_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("reset_outputs",
          64'({ifc.rq_gnt, ifc.sq_start, ifc.sq_rad, ifc.rs_valid, ifc.rs_id, ifc.rs_hyp, ifc.rs_err, ifc.ar_busy}),
          64'd0);
    tick();
    hy_rst = 1'b0;

    // Fairness: all four requesting continuously from pointer 0
    for (int l = 0; l < 4; l++) set_lane(l, 32'd6, 32'd8);
    ng = 0;
    nr = 0;
    for (int c = 0; c < 300 && nr < 5; c++) begin
      tick();
      ifc.rq_req = (ng < 5) ? 4'hF : 4'h0;
      #1;
      if (ifc.rq_gnt != '0 && ng < 5) begin
        check($sformatf("fair_gnt%0d", ng), 64'(ifc.rq_gnt), 64'(fair_gnt[ng]));
        ng++;
      end
      if (ifc.rs_valid) begin
        check($sformatf("fair_resp%0d", nr),
              64'({ifc.rs_id, ifc.rs_hyp, ifc.rs_err}), 64'({fair_id[nr], 32'd10, 2'b00}));
        nr++;
      end
    end
    check("fair_count", 64'(nr), 64'd5);

    // Table of single transactions
    for (int v = 0; v < NV; v++) begin
      tick();
      m_en = vecs[v].mdl;
      for (int l = 0; l < 4; l++) set_lane(l, 32'hDEAD_0000 + 32'(l), 32'hBEEF_0000 + 32'(l));
      set_lane(int'(vecs[v].id), vecs[v].s0, vecs[v].s1);
      ifc.rq_req = vecs[v].req;
      #1;
      check($sformatf("v%0d_idle", v), 64'({ifc.rs_valid, ifc.ar_busy}), 64'd0);
      check($sformatf("v%0d_gnt", v), 64'(ifc.rq_gnt), 64'(vecs[v].req));
      wait_resp(lat, st_t, rad);
      check($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].lat));
      check($sformatf("v%0d_start", v), 64'(st_t), 64'(vecs[v].st_t));
      check($sformatf("v%0d_rad", v), 64'(rad), 64'(vecs[v].rad));
      check($sformatf("v%0d_id", v), 64'(ifc.rs_id), 64'(vecs[v].id));
      check($sformatf("v%0d_hyp", v), 64'(ifc.rs_hyp), 64'(vecs[v].hyp));
      check($sformatf("v%0d_err", v), 64'(ifc.rs_err), 64'(vecs[v].err));
    end

    // Stale sq_valid in IDLE is ignored; sq_busy blocks the grant until it falls
    tick();
    m_en = 1'b1;
    tb_busy = 1'b1;
    tb_valid = 1'b1;
    tb_root = 32'd99;
    set_lane(2, 32'd0, 32'd3);
    ifc.rq_req = 4'b0100;
    #1;
    check("busy_block0", 64'(ifc.rq_gnt), 64'd0);
    tick();
    tb_valid = 1'b0;
    #1;
    check("stale_ignored", 64'({ifc.rq_gnt, ifc.rs_valid, ifc.ar_busy}), 64'd0);
    tick();
    tb_busy = 1'b0;
    #1;
    check("busy_release", 64'(ifc.rq_gnt), 64'(4'b0100));
    wait_resp(lat, st_t, rad);
    check("busy_resp", 64'({ifc.rs_id, ifc.rs_hyp, ifc.rs_err}), 64'({2'd2, 32'd3, 2'b00}));
    check("busy_lat", 64'(lat), 64'd2);

    // Backpressure with requester 3 pending
    tick();
    ifc.rs_ready = 1'b0;
    set_lane(0, 32'd0, 32'd9);
    set_lane(3, 32'd0, 32'd2);
    ifc.rq_req = 4'b0001;
    #1;
    check("bp_gnt", 64'(ifc.rq_gnt), 64'(4'b0001));
    tick();
    ifc.rq_req = 4'b1000;
    #1;
    check("bp_check_gnt", 64'(ifc.rq_gnt), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      check($sformatf("bp_hold%0d", k),
            64'({ifc.rs_valid, ifc.rs_id, ifc.rs_hyp, ifc.rs_err, ifc.rq_gnt}),
            64'({1'b1, 2'd0, 32'd9, 2'b00, 4'b0000}));
    end
    ifc.rs_ready = 1'b1;
    tick();
    #1;
    check("bp_next_gnt", 64'(ifc.rq_gnt), 64'(4'b1000));
    wait_resp(lat, st_t, rad);
    check("bp_next_resp", 64'({ifc.rs_id, ifc.rs_hyp, ifc.rs_err}), 64'({2'd3, 32'd2, 2'b00}));

    // Move the pointer off zero before testing reset in WAIT
    tick();
    set_lane(1, 32'd0, 32'd4);
    ifc.rq_req = 4'b0010;
    #1;
    check("pre_rst_gnt", 64'(ifc.rq_gnt), 64'(4'b0010));
    wait_resp(lat, st_t, rad);
    check("pre_rst_hyp", 64'(ifc.rs_hyp), 64'd4);

    // Reset while waiting on the sqrt unit
    tick();
    m_en = 1'b0;
    set_lane(2, 32'd3, 32'd4);
    ifc.rq_req = 4'b0100;
    #1;
    check("rst_gnt", 64'(ifc.rq_gnt), 64'(4'b0100));
    tick();
    ifc.rq_req = '0;
    tick();
    tick();
    hy_rst = 1'b1;
    tick();
    hy_rst = 1'b0;
    #1;
    check("rst_outputs",
          64'({ifc.rq_gnt, ifc.sq_start, ifc.sq_rad, ifc.rs_valid, ifc.rs_id, ifc.rs_hyp, ifc.rs_err, ifc.ar_busy}),
          64'd0);
    for (int l = 0; l < 4; l++) set_lane(l, 32'd0, 32'd5);
    ifc.rq_req = 4'hF;
    #1;
    check("rst_first_gnt", 64'(ifc.rq_gnt), 64'(4'b0001));
    wait_resp(lat, st_t, rad);
    check("rst_resp", 64'({ifc.rs_id, ifc.rs_hyp, ifc.rs_err}), 64'({2'd0, 32'd5, 2'b00}));

    tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
